// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle sequencer for the 16-bit CPU core.
// Fetches over a req/ack handshake into the instruction register, waits one cycle for the
// decoder to register its fields, then executes and optionally writes back.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   imem_req/addr     fetch request and address (= pc), asserted only in FETCH
//   imem_ack/rdata    fetch completion and instruction word
//   ir                instruction register, feeds the decoder
//   opcode, reg_b,    registered decoder fields, consumed in EXEC
//   imm_value
//   zero_flag         ALU zero flag, sampled in EXEC
//   alu_en, alu_op    ALU strobe (EXEC, ALU opcodes) and forwarded opcode (EXEC/WB)
//   rf_we, wb_sel_imm register-file write strobe and source select (WB)
//   pc, halted,       program counter, halt indicator, sticky illegal-opcode flag
//   illegal, state    debug view of the sequencer state
module cpu_control_unit #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         ir,
  input  logic [3:0]          opcode,
  input  logic [3:0]          reg_b,
  input  logic [3:0]          imm_value,
  input  logic                zero_flag,
  output logic                alu_en,
  output logic [3:0]          alu_op,
  output logic                rf_we,
  output logic                wb_sel_imm,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                illegal,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    StStart  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic                illegal_q, illegal_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] imm_sext;

  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign imm_sext = {{(PC_WIDTH-4){imm_value[3]}}, imm_value};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = 4'h0;
    illegal_d = illegal_q;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      // Capture the opcode from ir so alu_op is a flop output throughout EXEC and WB.
      StDecode: begin
        state_d  = StExec;
        alu_op_d = ir_q[15:12];
      end
      StExec: begin
        unique case (opcode)
          4'h0: begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            alu_op_d = alu_op_q;
            state_d  = StWb;
          end
          4'h9: begin
            pc_d    = PC_WIDTH'({reg_b, imm_value});
            state_d = StFetch;
          end
          4'hA: begin
            pc_d    = zero_flag ? (pc_inc + imm_sext) : pc_inc;
            state_d = StFetch;
          end
          4'hF: state_d = StHalt;
          default: begin
            illegal_d = 1'b1;
            pc_d      = pc_inc;
            state_d   = StFetch;
          end
        endcase
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StStart;
      pc_q      <= '0;
      ir_q      <= '0;
      alu_op_q  <= 4'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decode only flop outputs, so reset kills them without waiting for an edge.
  assign imem_req   = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign alu_en     = (state_q == StExec) && (alu_op_q != 4'h0) && !alu_op_q[3];
  assign rf_we      = (state_q == StWb);
  assign wb_sel_imm = (state_q == StWb) && (alu_op_q == 4'h8);

  assign ir      = ir_q;
  assign alu_op  = alu_op_q;
  assign pc      = pc_q;
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle sequencer for the 16-bit CPU core. It fetches instructions from instruction memory over a req/ack handshake and holds them in an instruction register that feeds the instruction decoder. It then reads back the decoder's registered fields and steps the datapath through EXEC and WB. It owns the program counter and issues the ALU-enable and register-file write strobes.

## Interface
- PC_WIDTH, 8, program counter and instruction-memory address width (>= 8)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  PC_WIDTH  fetch address (= pc), stable while imem_req high
- imem_ack  in  1  fetch complete; imem_rdata valid same cycle
- imem_rdata  in  16  fetched instruction
- ir  out  16  instruction register, drives decoder instruction input
- opcode  in  4  decoder opcode field (registered, valid one cycle after ir loads)
- reg_b  in  4  decoder reg_b field
- imm_value  in  4  decoder immediate field
- zero_flag  in  1  ALU zero flag, sampled in EXEC
- alu_en  out  1  one-cycle pulse in EXEC for ALU opcodes
- alu_op  out  4  opcode forwarded to ALU, valid in EXEC and WB, else 0
- rf_we  out  1  one-cycle register-file write pulse in WB
- wb_sel_imm  out  1  in WB: 1 = write imm_value (LDI), 0 = ALU result
- pc  out  PC_WIDTH  program counter
- halted  out  1  high in HALT
- illegal  out  1  sticky, set on an undefined opcode
- state  out  3  current state, for debug

## Operation
- States: START(0), FETCH(1), DECODE(2), EXEC(3), WB(4), HALT(5).
- Reset (async): state=START, pc=0, ir=0. All strobes (imem_req, alu_en, rf_we, wb_sel_imm) = 0. alu_op=0, halted=0, illegal=0.
- START -> FETCH unconditionally, one cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On a rising edge with imem_ack=1: ir <= imem_rdata, go to DECODE.
  - Otherwise stay in FETCH with ir unchanged.
- DECODE: one cycle. The decoder registers ir at this edge.
- EXEC acts on the decoder fields:
  - 0x0 NOP: pc <= pc+1, go to FETCH.
  - 0x1–0x7 ALU ops: alu_en=1, alu_op=opcode, go to WB.
  - 0x8 LDI: go to WB, with wb_sel_imm=1 in WB.
  - 0x9 JMP: pc <= {reg_b, imm_value}, zero-extended/truncated to PC_WIDTH. Go to FETCH.
  - 0xA BEQZ: if zero_flag, pc <= pc + 1 + sign_extend(imm_value); else pc <= pc+1. Go to FETCH.
  - 0xF HALT: go to HALT, pc unchanged.
  - 0xB–0xE: illegal <= 1, executed as NOP.
- WB: rf_we=1, pc <= pc+1, go to FETCH.
- HALT: terminal. imem_ack is ignored; only reset exits.
- PC arithmetic is modulo 2^PC_WIDTH; 0xFF+1 wraps to 0x00 at PC_WIDTH=8.
- imem_ack is ignored outside FETCH.

## Timing
- All outputs except imem_req, imem_addr and the strobes are registered. The strobes are decoded from the registered state only; no input-to-output combinational paths.
- Cycles per instruction with ack in the first FETCH cycle:
  - ALU/LDI: 4 (FETCH, DECODE, EXEC, WB).
  - NOP/JMP/BEQZ/illegal: 3.
  - Each extra cycle of ack latency adds one FETCH cycle.
- The new pc is visible on imem_addr in the first cycle of the next FETCH.
- imem_req drops in the cycle after ack is sampled. Back-to-back fetches have at least 2 cycles (3 for WB instructions) of req low between them.
- Reset asserted mid-fetch drops imem_req immediately, without waiting for a clock edge. A pending ack is discarded.
- Reset during WB suppresses rf_we immediately.

## Test plan
- **Reset:** assert reset during FETCH with imem_req high -> req=0, pc=0, ir=0, state=START at once. After release: START, then FETCH with imem_addr=0.
- **ALU op, ack in first cycle:** imem_rdata=0x1230 -> ir=0x1230. alu_en pulses in cycle 3 with alu_op=1; rf_we pulses in cycle 4; next FETCH at pc=1.
- **Delayed ack:** ack held low 3 cycles with imem_rdata toggling -> imem_addr stable, ir unchanged, no strobes. Instruction loads on the 4th cycle.
- **JMP:** 0x905A -> next fetch address 0x5A.
- **BEQZ at pc=0x10:**
  - 0xA00E with zero_flag=1 -> pc=0x0F.
  - zero_flag=0 -> pc=0x11.
  - At pc=0xFF with a not-taken branch -> pc wraps to 0x00.
- **LDI, illegal, HALT:**
  - LDI 0x8007 -> rf_we with wb_sel_imm=1.
  - Opcode 0xC -> illegal=1, sticky, pc advances.
  - 0xF000 -> halted=1, no further imem_req even with ack asserted, until reset.
